// File: rtl/vga_scanout.sv
// VGA 640x480@60 scan-out of the renderer's column line buffer, mapping iteration counts to RGB332.
// Optional feature macro: VGA_PALETTE_EN selects a 16-entry palette ROM instead of the greyscale map.
module vga_scanout #(
    parameter int         H_ACTIVE = 640,
    parameter int         H_FP     = 16,
    parameter int         H_SYNC   = 96,
    parameter int         H_BP     = 48,
    parameter int         V_ACTIVE = 480,
    parameter int         V_FP     = 10,
    parameter int         V_SYNC   = 2,
    parameter int         V_BP     = 33,
    parameter int         SCALE_SH = 1,
    parameter int         COLS     = 256,
    parameter logic [7:0] BORDER   = 8'h00
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    output logic [7:0] col_addr,
    input  logic [7:0] pixel_data,
    input  logic [7:0] max_iter,
    output logic       row_req,
    output logic [8:0] row_idx,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [7:0] rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] COLS_LIM   = 10'(COLS);
    localparam logic [7:0] COL_MAX    = 8'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       active;
    logic       frame_end;

    assign active    = (state != IDLE);
    assign frame_end = (h_count == H_LAST) && (v_count == V_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A frame in progress is never cut short: dropping enable only stops at the last pixel.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) state_next = RUN;
            end
            RUN: begin
                if (!enable) state_next = frame_end ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (enable)         state_next = RUN;
                else if (frame_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_count <= '0;
            v_count <= '0;
        end else if (!active) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
        end else begin
            h_count <= h_count + 10'd1;
        end
    end

    logic [9:0] col_full;
    logic [9:0] row_full;
    logic [9:0] v_next;
    logic [9:0] row_next;

    assign col_full    = h_count >> SCALE_SH;
    assign row_full    = v_count >> SCALE_SH;
    assign v_next      = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
    assign row_next    = v_next >> SCALE_SH;
    assign col_addr    = (col_full >= COLS_LIM) ? COL_MAX : col_full[7:0];
    assign frame_start = (state == RUN) && (h_count == 10'd0) && (v_count == 10'd0);

    logic de_now;
    logic hsync_now;
    logic vsync_now;
    logic border_now;
    logic row_req_now;

    assign de_now      = active && (h_count < H_ACT) && (v_count < V_ACT);
    assign hsync_now   = !(active && (h_count >= H_SYNC_BEG) && (h_count < H_SYNC_END));
    assign vsync_now   = !(active && (v_count >= V_SYNC_BEG) && (v_count < V_SYNC_END));
    assign border_now  = (col_full >= COLS_LIM) || (row_full >= COLS_LIM);
    // The last line always asks for row 0 so the next frame's first row is ready in time.
    assign row_req_now = active && (h_count == H_ACT)
                         && ((row_next != row_full) || (v_count == V_LAST))
                         && (row_next < COLS_LIM);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_req <= 1'b0;
            row_idx <= '0;
        end else begin
            row_req <= row_req_now;
            if (row_req_now) row_idx <= row_next[8:0];
        end
    end

    logic [7:0] mapped;
    logic [7:0] colour;

`ifdef VGA_PALETTE_EN
    // Entry k = {k[3:1], k[2:0], k[3:2]}.
    always_comb begin
        mapped = 8'h00;
        case (pixel_data[3:0])
            4'd0:    mapped = 8'h00;
            4'd1:    mapped = 8'h04;
            4'd2:    mapped = 8'h28;
            4'd3:    mapped = 8'h2C;
            4'd4:    mapped = 8'h51;
            4'd5:    mapped = 8'h55;
            4'd6:    mapped = 8'h79;
            4'd7:    mapped = 8'h7D;
            4'd8:    mapped = 8'h82;
            4'd9:    mapped = 8'h86;
            4'd10:   mapped = 8'hAA;
            4'd11:   mapped = 8'hAE;
            4'd12:   mapped = 8'hD3;
            4'd13:   mapped = 8'hD7;
            4'd14:   mapped = 8'hFB;
            4'd15:   mapped = 8'hFF;
            default: mapped = 8'h00;
        endcase
    end
`else
    assign mapped = {pixel_data[7:5], pixel_data[7:5], pixel_data[7:6]};
`endif

    assign colour = (pixel_data >= max_iter) ? 8'h00 : mapped;

    logic de_d1;
    logic hsync_d1;
    logic vsync_d1;
    logic border_d1;

    // Two-stage flag delay matches the one-cycle read latency of the buffer plus the output register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            de_d1     <= 1'b0;
            hsync_d1  <= 1'b1;
            vsync_d1  <= 1'b1;
            border_d1 <= 1'b1;
            de        <= 1'b0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            rgb       <= 8'h00;
        end else begin
            de_d1     <= de_now;
            hsync_d1  <= hsync_now;
            vsync_d1  <= vsync_now;
            border_d1 <= border_now;
            de        <= de_d1;
            hsync     <= hsync_d1;
            vsync     <= vsync_d1;
            rgb       <= (!de_d1 || border_d1) ? BORDER : colour;
        end
    end

endmodule
